// File: rtl/mem_stage_pkg.sv
// Shared opcodes, funct3 encodings, error codes and access-size type for the
// memory stage and its alignment helper.
package mem_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic: store lane enables/replication, load lane
// extraction with extension, and illegal/misaligned access detection.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        fault,
  output logic [1:0]  fault_code,
  output size_e       size,
  output logic        unsgn,
  input  size_e       ld_size,
  input  logic        ld_unsgn,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic        legal;
  logic        misaligned;
  logic [15:0] lane_bits;

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
        default:                             legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: legal = 1'b1;
        default:             legal = 1'b0;
      endcase
    end

    case (funct3[1:0])
      2'b00:   size = SZ_B;
      2'b01:   size = SZ_H;
      default: size = SZ_W;
    endcase
    unsgn = funct3[2];

    misaligned = ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));

    // Illegal funct3 outranks misalignment.
    fault      = 1'b0;
    fault_code = ERR_NONE;
    if ((is_load || is_store) && !legal) begin
      fault      = 1'b1;
      fault_code = ERR_ILLEGAL;
    end else if ((is_load || is_store) && misaligned) begin
      fault      = 1'b1;
      fault_code = ERR_MISALIGN;
    end
  end

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (is_store) begin
      case (size)
        SZ_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        SZ_H: begin
          be    = 4'b0011 << addr_lo;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    lane_bits = 16'(rdata >> {ld_lane, 3'b000});
    case (ld_size)
      SZ_B:    load_data = ld_unsgn ? {24'b0, lane_bits[7:0]}  : {{24{lane_bits[7]}}, lane_bits[7:0]};
      SZ_H:    load_data = ld_unsgn ? {16'b0, lane_bits[15:0]} : {{16{lane_bits[15]}}, lane_bits[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through to WB, or performs one
// load/store over a req/ack handshake with a bounded wait.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              rd_we_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [31:0]       rd_data_i,
  input  logic [31:0]       rs2_data_i,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_rd_we,
  output logic [4:0]        wb_rd_addr,
  output logic [31:0]       wb_rd_data,
  output logic              err_o,
  output logic [1:0]        err_code
);

  // state | meaning
  // IDLE  | ready to accept an instruction
  // WAIT  | dmem_req high, access outstanding
  typedef enum logic {IDLE, WAIT} state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        is_load, is_store, is_mem;
  logic        fault;
  logic [1:0]  fault_code;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;
  size_e       size, ld_size_q;
  logic        unsgn, ld_unsgn_q;
  logic [1:0]  ld_lane_q;
  logic        is_load_q;
  logic        rd_we_q;
  logic [4:0]  rd_addr_q;
  logic [7:0]  cnt_q;
  logic        accept, done, abort;

  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign is_mem   = is_load || is_store;

  lsu_align u_align (
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3_i),
    .addr_lo    (rd_data_i[1:0]),
    .store_data (rs2_data_i),
    .be         (be),
    .wdata      (wdata),
    .fault      (fault),
    .fault_code (fault_code),
    .size       (size),
    .unsgn      (unsgn),
    .ld_size    (ld_size_q),
    .ld_unsgn   (ld_unsgn_q),
    .ld_lane    (ld_lane_q),
    .rdata      (dmem_rdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          accept = 1'b1;
          if (is_mem && !fault) state_d = WAIT;
        end
      end
      WAIT: begin
        // An ack on the limit cycle still completes normally.
        if (dmem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TMO) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign stall_o  = (state_q == WAIT);
  assign dmem_req = (state_q == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd_we   <= 1'b0;
      wb_rd_addr <= '0;
      wb_rd_data <= '0;
      err_o      <= 1'b0;
      err_code   <= ERR_NONE;
      ld_size_q  <= SZ_B;
      ld_unsgn_q <= 1'b0;
      ld_lane_q  <= '0;
      is_load_q  <= 1'b0;
      rd_we_q    <= 1'b0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_rd_we <= 1'b0;
      err_o    <= 1'b0;
      err_code <= ERR_NONE;

      if (accept) begin
        if (!is_mem) begin
          wb_valid   <= 1'b1;
          wb_rd_we   <= rd_we_i && (rd_addr_i != 5'd0);
          wb_rd_addr <= rd_addr_i;
          wb_rd_data <= rd_data_i;
        end else if (fault) begin
          wb_valid   <= 1'b1;
          err_o      <= 1'b1;
          err_code   <= fault_code;
          wb_rd_addr <= rd_addr_i;
          wb_rd_data <= '0;
        end else begin
          dmem_addr  <= {rd_data_i[ADDR_W-1:2], 2'b00};
          dmem_we    <= is_store;
          dmem_be    <= be;
          dmem_wdata <= wdata;
          ld_size_q  <= size;
          ld_unsgn_q <= unsgn;
          ld_lane_q  <= rd_data_i[1:0];
          is_load_q  <= is_load;
          rd_we_q    <= is_load && rd_we_i && (rd_addr_i != 5'd0);
          rd_addr_q  <= rd_addr_i;
          cnt_q      <= '0;
        end
      end

      if (done) begin
        wb_valid   <= 1'b1;
        wb_rd_we   <= rd_we_q;
        wb_rd_addr <= rd_addr_q;
        wb_rd_data <= is_load_q ? load_data : '0;
      end else if (abort) begin
        wb_valid   <= 1'b1;
        err_o      <= 1'b1;
        err_code   <= ERR_TIMEOUT;
        wb_rd_addr <= rd_addr_q;
        wb_rd_data <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule
